// File: rtl/packet_transmitter.sv
// Output-port packet transmitter: pops stored packets from a FWFT FIFO and
// drives them out as a framed byte stream with XOR-CRC check and stall abort.
module packet_transmitter #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        rempty,
    input  logic [7:0]  rdata,
    output logic        rinc,
    input  logic        stop_in,
    output logic [7:0]  pdata_o,
    output logic        byte_en_o,
    output logic        packet_valid_o,
    output logic        pkt_done,
    output logic        crc_err,
    output logic        abort_o,
    output logic [15:0] pkt_count
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned STALL_W = 8;
    localparam int unsigned GAP_W   = 4;
    localparam int unsigned PCNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DST,
        S_SIZE,
        S_DATA,
        S_CRC,
        S_GAP
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   crc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [STALL_W-1:0]  stall_q;
    logic [GAP_W-1:0]    gap_q;
    logic                pop;

    // Popping is held off during reset so the FIFO never loses a byte the FSM ignores.
    assign pop  = rst && (state_q != S_GAP) && !rempty && !stop_in;
    assign rinc = pop;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            crc_q          <= '0;
            cnt_q          <= '0;
            stall_q        <= '0;
            gap_q          <= '0;
            pdata_o        <= '0;
            byte_en_o      <= 1'b0;
            packet_valid_o <= 1'b0;
            pkt_done       <= 1'b0;
            crc_err        <= 1'b0;
            abort_o        <= 1'b0;
            pkt_count      <= '0;
        end else begin
            byte_en_o <= pop;
            pkt_done  <= 1'b0;
            crc_err   <= 1'b0;
            abort_o   <= 1'b0;
            if (pop) begin
                pdata_o <= rdata;
            end

            case (state_q)
                S_IDLE: begin
                    stall_q <= '0;
                    if (pop) begin
                        crc_q          <= rdata;
                        packet_valid_o <= 1'b1;
                        state_q        <= S_DST;
                    end
                end

                S_DST, S_SIZE, S_DATA, S_CRC: begin
                    if (pop) begin
                        stall_q <= '0;
                        case (state_q)
                            S_DST: begin
                                crc_q   <= crc_q ^ rdata;
                                state_q <= S_SIZE;
                            end
                            S_SIZE: begin
                                crc_q   <= crc_q ^ rdata;
                                cnt_q   <= rdata[CNT_W-1:0];
                                state_q <= S_DATA;
                            end
                            S_DATA: begin
                                crc_q <= crc_q ^ rdata;
                                if (cnt_q == '0) begin
                                    state_q <= S_CRC;
                                end else begin
                                    cnt_q <= cnt_q - CNT_W'(1);
                                end
                            end
                            default: begin
                                pkt_done  <= 1'b1;
                                crc_err   <= (rdata != crc_q);
                                pkt_count <= pkt_count + PCNT_W'(1);
                                gap_q     <= '0;
                                state_q   <= S_GAP;
                            end
                        endcase
                    end else if (rempty) begin
                        // Only an empty FIFO counts toward the abort; backpressure alone never does.
                        if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                            abort_o        <= 1'b1;
                            packet_valid_o <= 1'b0;
                            stall_q        <= '0;
                            gap_q          <= '0;
                            state_q        <= S_GAP;
                        end else begin
                            stall_q <= stall_q + STALL_W'(1);
                        end
                    end
                end

                S_GAP: begin
                    packet_valid_o <= 1'b0;
                    stall_q        <= '0;
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter: table of packets plus hand-written
// backpressure, timeout, back-to-back and mid-packet reset sequences.
module tb_packet_transmitter;

    localparam int unsigned GAP = 2;
    localparam int unsigned TMO = 4;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        stop_in;
    logic [7:0]  pdata_o;
    logic        byte_en_o;
    logic        packet_valid_o;
    logic        pkt_done;
    logic        crc_err;
    logic        abort_o;
    logic [15:0] pkt_count;

    packet_transmitter #(
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk1          (clk1),
        .rst           (rst),
        .rempty        (rempty),
        .rdata         (rdata),
        .rinc          (rinc),
        .stop_in       (stop_in),
        .pdata_o       (pdata_o),
        .byte_en_o     (byte_en_o),
        .packet_valid_o(packet_valid_o),
        .pkt_done      (pkt_done),
        .crc_err       (crc_err),
        .abort_o       (abort_o),
        .pkt_count     (pkt_count)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int          len;
        logic [95:0] raw;
        logic        err;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] fifo_q [$];
    int         total = 0;
    int         bad = 0;
    int         tickn = 0;
    int         exp_count = 0;
    logic       popped;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (tick %0d)", nm, act, exp, tickn);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [95:0] raw, input int k);
        return raw[95-8*k -: 8];
    endfunction

    task automatic drive();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endtask

    // One clock: capture rinc as seen by the edge, then update the FIFO model.
    task automatic tick();
        @(posedge clk1);
        popped = rinc;
        #1;
        tickn++;
        if (popped && fifo_q.size() > 0) fifo_q.delete(0);
        drive();
    endtask

    task automatic push_vec(input int idx);
        for (int k = 0; k < vecs[idx].len; k++) fifo_q.push_back(byte_at(vecs[idx].raw, k));
        drive();
    endtask

    task automatic run_pkt(input int idx);
        int en = 0, first = -1, last = -1, vld = 0, done = 0, abrt = 0;
        logic err = 1'b0;
        push_vec(idx);
        repeat (vecs[idx].len + 6) begin
            tick();
            if (byte_en_o) begin
                if (en < vecs[idx].len)
                    chk($sformatf("v%0d_byte%0d", idx, en), 32'(pdata_o), 32'(byte_at(vecs[idx].raw, en)));
                if (first < 0) first = tickn;
                last = tickn;
                en++;
            end
            if (packet_valid_o) vld++;
            if (pkt_done) begin
                done++;
                err = crc_err;
                chk($sformatf("v%0d_done_byte", idx), 32'(pdata_o),
                    32'(byte_at(vecs[idx].raw, vecs[idx].len - 1)));
            end
            if (abort_o) abrt++;
        end
        exp_count++;
        chk($sformatf("v%0d_en_count", idx), 32'(en), 32'(vecs[idx].len));
        chk($sformatf("v%0d_en_span", idx), 32'(last - first + 1), 32'(vecs[idx].len));
        chk($sformatf("v%0d_valid_cycles", idx), 32'(vld), 32'(vecs[idx].len));
        chk($sformatf("v%0d_done_count", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_crc_err", idx), 32'(err), 32'(vecs[idx].err));
        chk($sformatf("v%0d_abort", idx), 32'(abrt), 32'd0);
        chk($sformatf("v%0d_pkt_count", idx), 32'(pkt_count), 32'(exp_count & 16'hFFFF));
    endtask

    initial begin
        vecs[0] = '{len: 7,  raw: 96'h01_05_02_AA_BB_CC_DB_00_00_00_00_00, err: 1'b0};
        vecs[1] = '{len: 7,  raw: 96'h01_05_02_AA_BB_CC_DA_00_00_00_00_00, err: 1'b1};
        vecs[2] = '{len: 5,  raw: 96'h03_07_00_55_51_00_00_00_00_00_00_00, err: 1'b0};
        vecs[3] = '{len: 6,  raw: 96'h0A_0B_F9_01_02_FB_00_00_00_00_00_00, err: 1'b0};
        vecs[4] = '{len: 12, raw: 96'h10_20_07_01_02_03_04_05_06_07_08_3F, err: 1'b0};
        vecs[5] = '{len: 6,  raw: 96'h0A_0B_F9_01_02_00_00_00_00_00_00_00, err: 1'b1};

        rst     = 1'b1;
        stop_in = 1'b0;
        drive();
        #2 rst = 1'b0;
        #1;
        chk("rst_pdata", 32'(pdata_o), 32'h0);
        chk("rst_outs", {26'd0, byte_en_o, packet_valid_o, pkt_done, crc_err, abort_o, rinc}, 32'h0);
        chk("rst_count", 32'(pkt_count), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_pkt(i);

        // Backpressure: stop_in held 5 cycles right after the SIZE pop.
        begin
            int npop = 0, stall_left = 0, en = 0, vld = 0, done = 0, nab = 0;
            logic stalled = 1'b0;
            push_vec(0);
            repeat (25) begin
                tick();
                if (stall_left > 0) begin
                    chk("bp_rinc", 32'(popped), 32'd0);
                    chk("bp_valid", 32'(packet_valid_o), 32'd1);
                    stall_left--;
                    if (stall_left == 0) stop_in = 1'b0;
                end
                if (popped) npop++;
                if (npop == 3 && !stalled) begin
                    stalled    = 1'b1;
                    stop_in    = 1'b1;
                    stall_left = 5;
                end
                if (byte_en_o) begin
                    if (en < 7) chk($sformatf("bp_byte%0d", en), 32'(pdata_o), 32'(byte_at(vecs[0].raw, en)));
                    en++;
                end
                if (packet_valid_o) vld++;
                if (pkt_done) begin
                    done++;
                    chk("bp_crc_err", 32'(crc_err), 32'd0);
                end
                if (abort_o) nab++;
            end
            exp_count++;
            chk("bp_en_count", 32'(en), 32'd7);
            chk("bp_valid_cycles", 32'(vld), 32'd12);
            chk("bp_done", 32'(done), 32'd1);
            chk("bp_abort", 32'(nab), 32'd0);
            chk("bp_pkt_count", 32'(pkt_count), 32'(exp_count));
        end

        // Timeout: packet stops after first data byte 0x11.
        begin
            int t11 = -1, tab = -1, nab = 0;
            logic vld_ab = 1'b1, vld_pre = 1'b0;
            fifo_q.push_back(8'h01);
            fifo_q.push_back(8'h05);
            fifo_q.push_back(8'h07);
            fifo_q.push_back(8'h11);
            drive();
            repeat (20) begin
                tick();
                if (byte_en_o && pdata_o == 8'h11) t11 = tickn;
                if (t11 >= 0 && tickn == t11 + 3) vld_pre = packet_valid_o;
                if (abort_o) begin
                    nab++;
                    if (tab < 0) begin
                        tab    = tickn;
                        vld_ab = packet_valid_o;
                    end
                end
            end
            chk("to_seen_11", 32'(t11 >= 0), 32'd1);
            chk("to_abort_delay", 32'(tab - t11), 32'd4);
            chk("to_abort_pulses", 32'(nab), 32'd1);
            chk("to_valid_before", 32'(vld_pre), 32'd1);
            chk("to_valid_at_abort", 32'(vld_ab), 32'd0);
            chk("to_pkt_count", 32'(pkt_count), 32'(exp_count));
            run_pkt(2);
        end

        // Back-to-back SIZE=00 packets; GAP=2 gives 3 cycles CRC pop to next SRC pop.
        begin
            int npop = 0, p_crc = -1, p_src2 = -1, done = 0;
            push_vec(2);
            for (int k = 0; k < 5; k++) fifo_q.push_back(k == 0 ? 8'h01 : k == 1 ? 8'h02 : k == 3 ? 8'h03 : 8'h00);
            drive();
            repeat (20) begin
                tick();
                if (popped) begin
                    npop++;
                    if (npop == 5) p_crc = tickn;
                    if (npop == 6) p_src2 = tickn;
                end
                if (pkt_done) begin
                    done++;
                    chk("b2b_crc_err", 32'(crc_err), 32'd0);
                end
            end
            exp_count += 2;
            chk("b2b_spacing", 32'(p_src2 - p_crc), 32'd3);
            chk("b2b_done", 32'(done), 32'd2);
            chk("b2b_pkt_count", 32'(pkt_count), 32'(exp_count));
        end

        // Reset while in DATA: outputs clear at once, then a fresh packet works.
        begin
            int npop = 0;
            push_vec(0);
            for (int k = 0; k < 10 && npop < 4; k++) begin
                tick();
                if (popped) npop++;
            end
            chk("mr_in_packet", 32'(packet_valid_o), 32'd1);
            #2 rst = 1'b0;
            fifo_q.delete();
            drive();
            #1;
            chk("mr_pdata", 32'(pdata_o), 32'h0);
            chk("mr_outs", {26'd0, byte_en_o, packet_valid_o, pkt_done, crc_err, abort_o, rinc}, 32'h0);
            chk("mr_count", 32'(pkt_count), 32'h0);
            tick();
            tick();
            rst = 1'b1;
            tick();
            exp_count = 0;
            run_pkt(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
